// File: rtl/reimu_hit_ctrl.sv
// reimu_hit_ctrl: player hit arbitration and invulnerability controller.
// Up to four bullet groups request a hit. One request per hit is granted
// round-robin. Each granted hit opens a window of COOLDOWN cycles in which
// every further request is ignored.
// Optional feature macro: REIMU_BOMB_EN adds a bomb input and a bomb stock.
// A bomb opens the same immunity window without costing a life.
module reimu_hit_ctrl #(
    parameter int COOLDOWN = 48
) (
    input  logic       clk_22,
    input  logic       rst,
    input  logic       gamestart,
    input  logic [3:0] hit_req,
    input  logic [1:0] life,
`ifdef REIMU_BOMB_EN
    input  logic       bomb,
    output logic [1:0] bombs_left,
`endif
    output logic       shot,
    output logic [3:0] hit_ack,
    output logic [1:0] hit_src,
    output logic       invuln,
    output logic [1:0] state,
    output logic       gameover
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PLAY = 2'b01,
        ST_COOL = 2'b10,
        ST_OVER = 2'b11
    } state_t;

    // The counter runs from COOLDOWN-1 down to 0, so the immunity window
    // lasts exactly COOLDOWN cycles including the cycle of the grant.
    localparam logic [7:0] COOL_LOAD = 8'(COOLDOWN - 1);

    state_t     state_q,   state_d;
    logic [7:0] coolCnt_q, coolCnt_d;
    logic [1:0] rrPtr_q,   rrPtr_d;
    logic [1:0] hitSrc_q,  hitSrc_d;
    logic       shot_q,    shot_d;
    logic [3:0] hitAck_q,  hitAck_d;

    logic       winFound;
    logic [1:0] winIdx;

`ifdef REIMU_BOMB_EN
    logic [1:0] bombsLeft_q, bombsLeft_d;
`endif

    // Round-robin search: start at rrPtr_q and step upward mod 4; the first set request wins
    always_comb begin
        winFound = 1'b0;
        winIdx   = rrPtr_q;
        for (int i = 0; i < 4; i++) begin
            if (!winFound && hit_req[rrPtr_q + 2'(i)]) begin
                winFound = 1'b1;
                winIdx   = rrPtr_q + 2'(i);
            end
        end
    end

    // Next-state logic. Grants are registered, so the shot and ack pulses appear one cycle after the request is sampled
    always_comb begin
        state_d   = state_q;
        coolCnt_d = coolCnt_q;
        rrPtr_d   = rrPtr_q;
        hitSrc_d  = hitSrc_q;
        shot_d    = 1'b0;
        hitAck_d  = 4'b0000;
`ifdef REIMU_BOMB_EN
        bombsLeft_d = bombsLeft_q;
`endif
        if (gamestart) begin
            // A restart wins over everything else and never produces a pulse.
            state_d   = ST_PLAY;
            coolCnt_d = 8'd0;
            rrPtr_d   = 2'd0;
`ifdef REIMU_BOMB_EN
            bombsLeft_d = 2'd2;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_PLAY: begin
                    if (life == 2'd0) begin
                        state_d = ST_OVER;
`ifdef REIMU_BOMB_EN
                    end else if (bomb && (bombsLeft_q != 2'd0)) begin
                        // A bomb outranks a same-cycle hit, and that hit is dropped.
                        state_d     = ST_COOL;
                        coolCnt_d   = COOL_LOAD;
                        bombsLeft_d = bombsLeft_q - 2'd1;
`endif
                    end else if (winFound) begin
                        state_d   = ST_COOL;
                        coolCnt_d = COOL_LOAD;
                        shot_d    = 1'b1;
                        hitAck_d  = 4'b0001 << winIdx;
                        hitSrc_d  = winIdx;
                        rrPtr_d   = winIdx + 2'd1;
                    end
                end
                ST_COOL: begin
                    if (coolCnt_q == 8'd0) begin
                        state_d = (life == 2'd0) ? ST_OVER : ST_PLAY;
                    end else begin
                        coolCnt_d = coolCnt_q - 8'd1;
                    end
                end
                ST_OVER: begin
                    state_d = ST_OVER;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers. A reset also cuts any cooldown that is in progress.
    always_ff @(posedge clk_22) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            coolCnt_q <= 8'd0;
            rrPtr_q   <= 2'd0;
            hitSrc_q  <= 2'd0;
            shot_q    <= 1'b0;
            hitAck_q  <= 4'b0000;
`ifdef REIMU_BOMB_EN
            bombsLeft_q <= 2'd2;
`endif
        end else begin
            state_q   <= state_d;
            coolCnt_q <= coolCnt_d;
            rrPtr_q   <= rrPtr_d;
            hitSrc_q  <= hitSrc_d;
            shot_q    <= shot_d;
            hitAck_q  <= hitAck_d;
`ifdef REIMU_BOMB_EN
            bombsLeft_q <= bombsLeft_d;
`endif
        end
    end

    assign shot     = shot_q;
    assign hit_ack  = hitAck_q;
    assign hit_src  = hitSrc_q;
    assign state    = state_q;
    assign invuln   = (state_q == ST_COOL);
    assign gameover = (state_q == ST_OVER);
`ifdef REIMU_BOMB_EN
    assign bombs_left = bombsLeft_q;
`endif

endmodule
